// File: rtl/exp_sum_accumulator_pkg.sv
// Shared softmax definitions: accumulator FSM encoding and width helpers.
package exp_sum_accumulator_pkg;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    // Counter width able to hold 0..num inclusive.
    function automatic int unsigned cnt_w(input int unsigned num);
        return $clog2(num + 1);
    endfunction

    function automatic int unsigned acc_w(input int unsigned data_size, input int unsigned guard);
        return data_size + guard;
    endfunction

endpackage

// File: rtl/exp_sum_accumulator_sat_shift.sv
// Right-shifts the accumulator and saturates the result to the output width.
module sat_shift
    import exp_sum_accumulator_pkg::*;
#(
    parameter int unsigned IN_W  = 36,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned SHIFT = 4
) (
    input  logic [IN_W-1:0]  value,
    output logic [OUT_W-1:0] result_c
);

    logic [IN_W-1:0] shifted;

    assign shifted = value >> SHIFT;

    generate
        if (IN_W > OUT_W) begin : g_sat
            assign result_c = (|shifted[IN_W-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];
        end else begin : g_pass
            assign result_c = OUT_W'(shifted);
        end
    endgenerate

endmodule

// File: rtl/exp_sum_accumulator.sv
// Frame accumulator for softmax exponentials: sums up to NUM_DATA elements,
// presents the scaled, saturated sum with a valid/ready handshake.
module exp_sum_accumulator
    import exp_sum_accumulator_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned NUM_DATA   = 10,
    parameter int unsigned GUARD_BITS = 4,
    parameter int unsigned FRAC_SHIFT = 4,
    localparam int unsigned CNT_W     = cnt_w(NUM_DATA),
    localparam int unsigned ACC_W     = acc_w(DATA_SIZE, GUARD_BITS)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic                 last_i,
    output logic [DATA_SIZE-1:0] sum_o,
    output logic                 sum_valid_o,
    input  logic                 sum_ready_i,
    output logic [CNT_W-1:0]     count_o,
    output logic                 overflow_o
);

    logic [0:0]           state_q;
    logic [0:0]           state_nxt;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     acc_nxt;
    logic [ACC_W:0]       acc_sum;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 ovf_q;
    logic                 ovf_nxt;
    logic                 load_sum;
    logic                 ready_q;
    logic                 valid_q;
    logic [DATA_SIZE-1:0] sum_q;
    logic [DATA_SIZE-1:0] sat_c;

    // sum_o is loaded from the post-add value so the final element is included.
    sat_shift #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_SIZE),
        .SHIFT (FRAC_SHIFT)
    ) u_sat_shift (
        .value    (acc_nxt),
        .result_c (sat_c)
    );

    always_comb begin
        state_nxt = state_q;
        acc_nxt   = acc_q;
        cnt_nxt   = cnt_q;
        ovf_nxt   = ovf_q;
        load_sum  = 1'b0;
        acc_sum   = {1'b0, acc_q} + (ACC_W + 1)'(data_i);
        if (state_q == ST_ACCUM) begin
            if (data_valid_i) begin
                cnt_nxt = cnt_q + CNT_W'(1);
                // Once the carry is lost the frame total is meaningless; pin it at max.
                if (ovf_q || acc_sum[ACC_W]) begin
                    acc_nxt = '1;
                    ovf_nxt = 1'b1;
                end else begin
                    acc_nxt = acc_sum[ACC_W-1:0];
                end
                if (last_i || (cnt_nxt == CNT_W'(NUM_DATA))) begin
                    state_nxt = ST_DONE;
                    load_sum  = 1'b1;
                end
            end
        end else begin
            if (sum_ready_i) begin
                state_nxt = ST_ACCUM;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                ovf_nxt   = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            acc_q   <= acc_nxt;
            cnt_q   <= cnt_nxt;
            ovf_q   <= ovf_nxt;
            ready_q <= (state_nxt == ST_ACCUM);
            valid_q <= (state_nxt == ST_DONE);
            if (load_sum) begin
                sum_q <= sat_c;
            end
        end
    end

    assign data_ready_o = ready_q;
    assign sum_valid_o  = valid_q;
    assign sum_o        = sum_q;
    assign count_o      = cnt_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_exp_sum_accumulator.sv
// Directed bench for exp_sum_accumulator: default instance plus an overflow-prone instance.
module tb_exp_sum_accumulator;

    logic        clk;
    logic        rst;

    logic [31:0] a_data;
    logic        a_valid;
    logic        a_last;
    logic        a_sum_ready;
    logic        a_ready;
    logic [31:0] a_sum;
    logic        a_sum_valid;
    logic [3:0]  a_count;
    logic        a_ovf;

    logic [31:0] b_data;
    logic        b_valid;
    logic        b_last;
    logic        b_sum_ready;
    logic        b_ready;
    logic [31:0] b_sum;
    logic        b_sum_valid;
    logic [3:0]  b_count;
    logic        b_ovf;

    int checks;
    int errors;

    exp_sum_accumulator u_dut_a (
        .clock_i      (clk),
        .reset_i      (rst),
        .data_i       (a_data),
        .data_valid_i (a_valid),
        .data_ready_o (a_ready),
        .last_i       (a_last),
        .sum_o        (a_sum),
        .sum_valid_o  (a_sum_valid),
        .sum_ready_i  (a_sum_ready),
        .count_o      (a_count),
        .overflow_o   (a_ovf)
    );

    exp_sum_accumulator #(
        .GUARD_BITS (2),
        .FRAC_SHIFT (0)
    ) u_dut_b (
        .clock_i      (clk),
        .reset_i      (rst),
        .data_i       (b_data),
        .data_valid_i (b_valid),
        .data_ready_o (b_ready),
        .last_i       (b_last),
        .sum_o        (b_sum),
        .sum_valid_o  (b_sum_valid),
        .sum_ready_i  (b_sum_ready),
        .count_o      (b_count),
        .overflow_o   (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic rdy, input logic vld,
                         input logic [31:0] sum, input logic [3:0] cnt, input logic ovf);
        chk({tag, ".ready"}, 64'(a_ready), 64'(rdy));
        chk({tag, ".valid"}, 64'(a_sum_valid), 64'(vld));
        chk({tag, ".sum"}, 64'(a_sum), 64'(sum));
        chk({tag, ".count"}, 64'(a_count), 64'(cnt));
        chk({tag, ".ovf"}, 64'(a_ovf), 64'(ovf));
    endtask

    // Present one element to A for one clock edge; leaves inputs asserted.
    task automatic beat_a(input logic [31:0] d, input logic l);
        a_data  = d;
        a_valid = 1'b1;
        a_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic beat_b(input logic [31:0] d);
        b_data  = d;
        b_valid = 1'b1;
        b_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_data  = '0;
    endtask

    task automatic handshake_a();
        a_sum_ready = 1'b1;
        @(posedge clk);
        #1;
        a_sum_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_data = '0; a_valid = 1'b0; a_last = 1'b0; a_sum_ready = 1'b0;
        b_data = '0; b_valid = 1'b0; b_last = 1'b0; b_sum_ready = 1'b0;
        #12;
        chk_a("in_reset", 1'b1, 1'b0, 32'h0, 4'd0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_a("after_reset", 1'b1, 1'b0, 32'h0, 4'd0, 1'b0);
        chk("b_after_reset.ready", 64'(b_ready), 64'd1);

        // Ten beats of 0x10 fill the frame: 0xA0 >> 4 = 0xA.
        for (int i = 0; i < 9; i++) beat_a(32'h10, 1'b0);
        chk_a("full9", 1'b1, 1'b0, 32'h0, 4'd9, 1'b0);
        beat_a(32'h10, 1'b0);
        idle_a();
        chk_a("full10", 1'b0, 1'b1, 32'h0000000A, 4'd10, 1'b0);
        handshake_a();
        chk_a("full_hs", 1'b1, 1'b0, 32'h0000000A, 4'd0, 1'b0);

        // Early termination by last_i: 0x600 >> 4 = 0x60.
        beat_a(32'h100, 1'b0);
        beat_a(32'h200, 1'b0);
        chk_a("last2", 1'b1, 1'b0, 32'h0000000A, 4'd2, 1'b0);
        beat_a(32'h300, 1'b1);
        chk_a("last3", 1'b0, 1'b1, 32'h00000060, 4'd3, 1'b0);

        // Back-pressure: data presented in DONE must be ignored.
        a_data = 32'h999; a_valid = 1'b1; a_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_a("stall", 1'b0, 1'b1, 32'h00000060, 4'd3, 1'b0);
        end
        a_sum_ready = 1'b1;
        @(posedge clk);
        #1;
        a_sum_ready = 1'b0;
        idle_a();
        chk_a("stall_hs", 1'b1, 1'b0, 32'h00000060, 4'd0, 1'b0);
        beat_a(32'h20, 1'b0);
        beat_a(32'h20, 1'b1);
        idle_a();
        chk_a("after_stall", 1'b0, 1'b1, 32'h00000004, 4'd2, 1'b0);
        handshake_a();

        // last_i without data_valid_i must not count or end the frame.
        a_last = 1'b1;
        @(posedge clk);
        #1;
        a_last = 1'b0;
        chk_a("last_no_valid", 1'b1, 1'b0, 32'h00000004, 4'd0, 1'b0);

        // Overflow on B: 4*(2^32-1) fits in 34 bits, the fifth add carries out.
        for (int i = 0; i < 4; i++) beat_b(32'hFFFFFFFF);
        chk("b4.ovf", 64'(b_ovf), 64'd0);
        chk("b4.count", 64'(b_count), 64'd4);
        beat_b(32'hFFFFFFFF);
        chk("b5.ovf", 64'(b_ovf), 64'd1);
        for (int i = 0; i < 5; i++) beat_b(32'hFFFFFFFF);
        b_valid = 1'b0;
        chk("b10.valid", 64'(b_sum_valid), 64'd1);
        chk("b10.sum", 64'(b_sum), 64'hFFFFFFFF);
        chk("b10.ovf", 64'(b_ovf), 64'd1);
        chk("b10.count", 64'(b_count), 64'd10);
        b_sum_ready = 1'b1;
        @(posedge clk);
        #1;
        b_sum_ready = 1'b0;
        chk("b_hs.ovf", 64'(b_ovf), 64'd0);
        chk("b_hs.ready", 64'(b_ready), 64'd1);

        // Asynchronous mid-frame reset discards the partial frame.
        for (int i = 0; i < 4; i++) beat_a(32'h50, 1'b0);
        idle_a();
        chk_a("pre_reset", 1'b1, 1'b0, 32'h00000004, 4'd4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_a("async_reset", 1'b1, 1'b0, 32'h0, 4'd0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) beat_a(32'h10, 1'b0);
        idle_a();
        chk_a("post_reset", 1'b0, 1'b1, 32'h0000000A, 4'd10, 1'b0);
        handshake_a();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_sum_accumulator.md
EXP_SUM_ACCUMULATOR -- requirements
Module: exp_sum_accumulator

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: width of input element and of sum_o.
REQ-002 SHALL have parameter NUM_DATA, default 10: maximum elements per frame (>=1).
REQ-003 SHALL have parameter GUARD_BITS, default 4: extra accumulator MSBs; ACC_W = DATA_SIZE+GUARD_BITS.
REQ-004 SHALL have parameter FRAC_SHIFT, default 4: right shift applied to accumulator to form sum_o.
REQ-005 SHALL have port clock_i  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port data_i  input  DATA_SIZE  unsigned exp element.
REQ-008 SHALL have port data_valid_i  input  1  data_i valid.
REQ-009 SHALL have port data_ready_o  output  1  block can accept an element.
REQ-010 SHALL have port last_i  input  1  qualifies accepted element as frame end (early termination).
REQ-011 SHALL have port sum_o  output  DATA_SIZE  scaled frame sum.
REQ-012 SHALL have port sum_valid_o  output  1  sum_o valid.
REQ-013 SHALL have port sum_ready_i  input  1  consumer accepts sum_o.
REQ-014 SHALL have port count_o  output  CNT_W=clog2(NUM_DATA+1)  elements accepted in current frame.
REQ-015 SHALL have port overflow_o  output  1  sticky accumulator overflow for current frame.

Function
REQ-016 SHALL implement FSM states ACCUM and DONE; data_ready_o=1 only in ACCUM, sum_valid_o=1 only in DONE.
REQ-017 SHALL accept an element on a cycle where data_valid_i and data_ready_o are both 1; acc <= acc + data_i (zero-extended to ACC_W), count_o increments.
REQ-018 SHALL transition ACCUM->DONE on the accepting edge of an element with last_i=1 or whose acceptance makes count_o equal NUM_DATA.
REQ-019 SHALL assert sum_valid_o the cycle after the final element is accepted, with sum_o including that element (latency 1).
REQ-020 SHALL register sum_o on entering DONE as acc >> FRAC_SHIFT, saturated to all-ones if the shifted value exceeds DATA_SIZE bits.
REQ-021 SHALL, if an addition carries out of ACC_W, hold acc at all-ones for the rest of the frame and set overflow_o until frame handshake.
REQ-022 SHALL hold sum_o, sum_valid_o, count_o, overflow_o stable in DONE while sum_ready_i=0.
REQ-023 SHALL, on sum_valid_o & sum_ready_i, return to ACCUM next cycle with acc, count_o, overflow_o cleared; sum_o retains last value.
REQ-024 SHALL ignore data_valid_i and last_i while in DONE, including the handshake cycle.
REQ-025 SHALL ignore last_i when data_valid_i=0.

Reset
REQ-026 SHALL on reset_i=1 immediately force state ACCUM, acc=0, sum_o=0, sum_valid_o=0, count_o=0, overflow_o=0; data_ready_o=1 after release.
REQ-027 SHALL discard any partial frame on mid-frame reset; next frame sums from zero.

Structure
REQ-028 SHALL place FSM state encoding and CNT_W/ACC_W derivation helpers in the shared softmax package.
REQ-029 SHALL use one sub-module, sat_shift, for the shift-and-saturate of acc to sum_o.

Verification
REQ-030 SHALL test: defaults, 10 beats of 0x10 -> sum_valid_o 1 cycle after 10th beat, sum_o=0x0000000A, count_o=10, overflow_o=0.
REQ-031 SHALL test: beats 0x100,0x200,0x300 with last_i on 3rd -> sum_o=0x00000060, count_o=3.
REQ-032 SHALL test: sum_ready_i low 5 cycles with data_valid_i high -> no element accepted, outputs stable; after handshake, next frame of 2x0x20 (last_i) -> sum_o=0x00000004.
REQ-033 SHALL test: GUARD_BITS=2, FRAC_SHIFT=0, 10 beats of 0xFFFFFFFF -> overflow_o=1 from 5th beat, sum_o=0xFFFFFFFF.
REQ-034 SHALL test: reset_i pulsed asynchronously after 4 beats of 0x50 -> all outputs 0 immediately; then 10 beats of 0x10 -> sum_o=0x0000000A.
